array_multiplier_accumulator: RTL



---
 rtl/array_multiplier_accumulator_pkg.sv | 15 +
 rtl/array_multiplier_accumulator_if.sv | 37 +++
 rtl/array_multiplier_accumulator_mult.sv | 25 ++
 rtl/array_multiplier_accumulator.sv | 87 ++++++++
 4 files changed

// File: rtl/array_multiplier_accumulator_pkg.sv
// Shared types and defaults for the multiply-accumulate stage.
// Imported by the interface, the multiplier and the accumulator top.
package array_multiplier_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } mac_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_GUARD_BITS  = 8;
  localparam int DEF_COUNT_WIDTH = 16;

endpackage

// File: rtl/array_multiplier_accumulator_if.sv
// Operand stream in, accumulated result out, both valid/ready.
// The master drives operands and consumes the result.
interface array_multiplier_accumulator_if
  import array_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = 2 * DEF_DATA_WIDTH + DEF_GUARD_BITS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);

  logic                   clear_i;
  logic [DATA_WIDTH-1:0]  multiplicand_i;
  logic [DATA_WIDTH-1:0]  multiplier_i;
  logic                   valid_i;
  logic                   last_i;
  logic                   ready_o;
  logic [ACC_WIDTH-1:0]   accumulator_o;
  logic [COUNT_WIDTH-1:0] count_o;
  logic                   overflow_o;
  logic                   valid_o;
  logic                   ready_i;

  modport master (
    output clear_i, multiplicand_i, multiplier_i,
    output valid_i, last_i, ready_i,
    input  ready_o, accumulator_o, count_o,
    input  overflow_o, valid_o
  );

  modport slave (
    input  clear_i, multiplicand_i, multiplier_i,
    input  valid_i, last_i, ready_i,
    output ready_o, accumulator_o, count_o,
    output overflow_o, valid_o
  );

endinterface

// File: rtl/array_multiplier_accumulator_mult.sv
// Combinational unsigned array multiplier.
// Sums one shifted partial product per multiplier bit.
module array_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   multiplicand_i,
  input  logic [DATA_WIDTH-1:0]   multiplier_i,
  output logic [2*DATA_WIDTH-1:0] product_o
);

  logic [2*DATA_WIDTH-1:0] mcand_ext;

  assign mcand_ext = {{DATA_WIDTH{1'b0}}, multiplicand_i};

  // accumulate the partial-product rows
  always_comb begin
    product_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (multiplier_i[i]) begin
        product_o = product_o + (mcand_ext << i);
      end
    end
  end

endmodule

// File: rtl/array_multiplier_accumulator.sv
// Registered-operand multiply-accumulate with burst framing.
// Final sum is held and offered on a valid/ready handshake.
module array_multiplier_accumulator
  import array_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int GUARD_BITS  = DEF_GUARD_BITS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic clk_i,
  input logic rst_i,
  array_multiplier_accumulator_if.slave bus
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;

  mac_state_t             state;
  logic [DATA_WIDTH-1:0]  op_a;
  logic [DATA_WIDTH-1:0]  op_b;
  logic                   op_valid;
  logic [ACC_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0] count;
  logic                   overflow;
  logic [PROD_WIDTH-1:0]  product;
  logic [ACC_WIDTH:0]     sum_ext;
  logic                   ready;
  logic                   accept;

  array_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .multiplicand_i(op_a),
    .multiplier_i  (op_b),
    .product_o     (product)
  );

  assign ready   = (state == ACCUM) & ~bus.clear_i & ~rst_i;
  assign accept  = bus.valid_i & ready;
  assign sum_ext = {1'b0, acc}
                 + {{(GUARD_BITS + 1){1'b0}}, product};

  // operand register, accumulator, counter, overflow and burst FSM
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      state    <= ACCUM;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      op_valid <= accept;
      if (accept) begin
        op_a <= bus.multiplicand_i;
        op_b <= bus.multiplier_i;
      end
      if (op_valid) begin
        acc      <= sum_ext[ACC_WIDTH-1:0];
        overflow <= overflow | sum_ext[ACC_WIDTH];
        if (count != '1) count <= count + 1'b1;
      end
      case (state)
        ACCUM: if (accept && bus.last_i) state <= DRAIN;
        DRAIN: if (op_valid) state <= DONE;
        DONE: begin
          if (bus.ready_i) begin
            state    <= ACCUM;
            op_valid <= 1'b0;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = (state == DONE);
  assign bus.accumulator_o = acc;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;

endmodule
